ctrl_report_packetizer: RTL and testbench
=========================================

Name: ctrl_report_packetizer

Overview:
- Upstream stage of the UART transmitter: accepts whole controller reports (parallel words) and issues them as framed byte sequences over the transmitter's trmt/tx_data/tx_done handshake.
- Frame, in byte order: header, payload bytes (most-significant first), checksum.
- A one-entry pending buffer absorbs a report arriving mid-frame; overwritten reports are counted.

Parameters:
- NUM_BYTES, 4: payload bytes per report, legal range 1..8.
- HDR_BYTE, 8'hA5: first byte of every frame.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- rpt_vld  input  1  report strobe; one-cycle pulse per report
- rpt_data  input  8*NUM_BYTES  report payload, sampled when rpt_vld=1
- trmt  output  1  one-cycle start pulse to the UART transmitter
- tx_data  output  8  byte to transmit, valid while trmt=1
- tx_done  input  1  transmitter done level; clears the cycle after trmt, sets at end of byte
- busy  output  1  high from frame start until the last byte's tx_done
- drop_cnt  output  8  count of reports lost to pending overwrite; saturates at 8'hFF

Behaviour:
- Reset (async, rst=1): state IDLE, trmt=0, tx_data=8'h00, busy=0, drop_cnt=0, pending buffer empty, byte index=0.
- Frame length: FLEN = NUM_BYTES+2 bytes (NUM_BYTES+3 with PKT_SEQ_EN).
- Checksum: two's complement of the 8-bit sum (modulo 256) of the payload bytes, so payload sum + checksum = 8'h00. Header and sequence byte are excluded.
- States:
  - IDLE: on rpt_vld, latch rpt_data into the frame register, set busy, go to SEND next cycle (1-cycle latency from rpt_vld to trmt).
  - SEND: trmt=1 for exactly one cycle with tx_data = byte[index]; go to WAIT_CLR.
  - WAIT_CLR: one-cycle guard, so the stale tx_done from the previous byte is ignored; go to WAIT_DONE.
  - WAIT_DONE: hold until tx_done=1.
    - If index < FLEN-1: index+1, go to SEND.
    - Else (frame complete): if pending buffer is full, move it to the frame register, clear pending, index=0, go to SEND (busy stays 1). Otherwise busy=0, go to IDLE.
- tx_done is never awaited before the first trmt; its reset value of 0 must not stall the block.
- Checksum is computed from the frame register at latch time; its value is registered.
- Capture outside IDLE:
  - rpt_vld with pending empty: pending <= rpt_data.
  - rpt_vld with pending full: pending overwritten with the new report, drop_cnt+1 (saturating).
- rpt_vld in the same cycle as the frame-complete transfer: the new report goes to pending after the transfer, so no drop is counted.
- tx_data holds its last value outside SEND; only trmt qualifies it.
- rst asserted mid-frame: immediate return to reset values. The partially sent frame is abandoned; no completion is attempted.

Optional Feature:
- Macro: PKT_SEQ_EN.
- Defined: an 8-bit sequence byte is inserted after the header. It is 0 after reset, increments by 1 per frame started, and wraps 8'hFF -> 8'h00.
- Undefined: no sequence byte and no sequence counter logic; frame is header, payload, checksum.

Test Plan:
- Defaults, rpt_data=32'h12345678 pulsed once, transmitter model returns tx_done 20 cycles after each trmt -> bytes A5,12,34,56,78,EC in order; exactly 6 trmt pulses; busy falls the cycle after the 6th tx_done.
- Two reports 32'h00000001 then 32'hFFFFFFFF, the second arriving mid-frame -> frames A5,00,00,00,01,FF then A5,FF,FF,FF,FF,04 back-to-back with no IDLE cycle; drop_cnt=0.
- Three reports during one frame -> second is overwritten; first and third frames sent; drop_cnt=1. Repeat 300 overwrites -> drop_cnt saturates at FF.
- rst pulsed while the 3rd byte is in WAIT_DONE -> trmt=0, busy=0, drop_cnt=0 immediately; next report produces a full fresh frame starting with A5.
- tx_done held high continuously across trmt (stale level) -> WAIT_CLR guard still consumes one cycle per byte; no byte skipped and no duplicate trmt.
- With PKT_SEQ_EN defined, 257 frames of 32'h0 -> sequence bytes 00..FF then 00; each frame is A5,seq,00,00,00,00,00.

Source files
------------

// File: rtl/ctrl_report_packetizer_if.sv
// Purpose : bundles the report-capture and UART-transmitter handshake of ctrl_report_packetizer.
// Latency : n/a (wiring only).
// Backpressure: n/a; the packetizer (master) paces bytes with trmt and waits on tx_done.
//
// Signals:
//   rpt_vld/rpt_data  report strobe and payload (8*NUM_BYTES bits)
//   trmt/tx_data      one-cycle byte start pulse and its byte
//   tx_done           transmitter done level
//   busy              frame in progress
//   drop_cnt          saturating count of overwritten pending reports
// Modports: master = packetizer side, slave = report source / transmitter side.
interface ctrl_report_packetizer_if #(
    parameter int NUM_BYTES = 4
);
    logic                   rpt_vld;
    logic [8*NUM_BYTES-1:0] rpt_data;
    logic                   trmt;
    logic [7:0]             tx_data;
    logic                   tx_done;
    logic                   busy;
    logic [7:0]             drop_cnt;

    modport master (
        input  rpt_vld, rpt_data, tx_done,
        output trmt, tx_data, busy, drop_cnt
    );

    modport slave (
        output rpt_vld, rpt_data, tx_done,
        input  trmt, tx_data, busy, drop_cnt
    );
endinterface

// File: rtl/ctrl_report_packetizer.sv
// Purpose : frames parallel controller reports as header/payload/checksum byte streams for a UART transmitter.
// Latency : first trmt one cycle after rpt_vld when idle; each byte waits for tx_done after a one-cycle guard.
// Backpressure: none upstream; one pending slot absorbs a mid-frame report, a further report overwrites it and bumps drop_cnt.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   bus       ctrl_report_packetizer_if.master (rpt_vld, rpt_data, trmt, tx_data, tx_done, busy, drop_cnt)
// Parameters: NUM_BYTES (1..8) payload bytes per report, HDR_BYTE first byte of every frame.
// Optional build macro PKT_SEQ_EN: inserts a per-frame 8-bit sequence byte after the header.
module ctrl_report_packetizer #(
    parameter int         NUM_BYTES = 4,
    parameter logic [7:0] HDR_BYTE  = 8'hA5
) (
    input  logic                             clk,
    input  logic                             rst,
    ctrl_report_packetizer_if.master         bus
);

`ifdef PKT_SEQ_EN
    localparam int SEQ_BYTES = 1;
`else
    localparam int SEQ_BYTES = 0;
`endif
    localparam int FLEN = NUM_BYTES + 2 + SEQ_BYTES;
    localparam int IW   = $clog2(FLEN);
    localparam int DW   = 8 * NUM_BYTES;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_CLR,
        ST_WAIT_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [DW-1:0]   r_frame;
    logic [7:0]      r_csum;
    logic [DW-1:0]   r_pend;
    logic            r_pend_vld;
    logic [IW-1:0]   r_idx;
    logic            r_busy;
    logic [7:0]      r_drop;
    logic [7:0]      r_tx_data;
`ifdef PKT_SEQ_EN
    logic [7:0]      r_seq_cnt;   // number of the next frame to start
    logic [7:0]      r_seq;       // sequence byte of the frame in flight
`endif

    logic            w_load_pend;
    logic            w_load_in;
    logic            w_load;
    logic            w_idx_inc;
    logic            w_finish;
    logic            w_last;
    logic [DW-1:0]   w_src;
    logic [7:0]      w_byte;

    // Checksum makes payload sum + checksum == 0 (mod 256).
    function automatic logic [7:0] f_csum(input logic [DW-1:0] d);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < NUM_BYTES; i++) begin
            s = s + d[8*i +: 8];
        end
        return 8'h00 - s;
    endfunction

    assign w_last = (r_idx == IW'(FLEN - 1));
    assign w_load = w_load_pend | w_load_in;
    assign w_src  = w_load_pend ? r_pend : bus.rpt_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_pend = 1'b0;
        w_load_in   = 1'b0;
        w_idx_inc   = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A pending report can be left here if it arrived in the very
                // cycle a frame finished without anything queued behind it.
                if (r_pend_vld) begin
                    w_load_pend = 1'b1;
                    w_state_nxt = ST_SEND;
                end else if (bus.rpt_vld) begin
                    w_load_in   = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                w_state_nxt = ST_WAIT_CLR;
            end
            ST_WAIT_CLR: begin
                // tx_done may still show the previous byte's completion here.
                w_state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (bus.tx_done) begin
                    if (!w_last) begin
                        w_idx_inc   = 1'b1;
                        w_state_nxt = ST_SEND;
                    end else if (r_pend_vld) begin
                        w_load_pend = 1'b1;
                        w_state_nxt = ST_SEND;
                    end else begin
                        w_finish    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Byte select: header, [sequence], payload MSB first, checksum.
    always_comb begin
        w_byte = r_csum;
        for (int p = 0; p < NUM_BYTES; p++) begin
            if (r_idx == IW'(p + 1 + SEQ_BYTES)) begin
                w_byte = r_frame[8*(NUM_BYTES-1-p) +: 8];
            end
        end
`ifdef PKT_SEQ_EN
        if (r_idx == IW'(1)) begin
            w_byte = r_seq;
        end
`endif
        if (r_idx == '0) begin
            w_byte = HDR_BYTE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame    <= '0;
            r_csum     <= 8'h00;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_drop     <= 8'h00;
            r_tx_data  <= 8'h00;
`ifdef PKT_SEQ_EN
            r_seq_cnt  <= 8'h00;
            r_seq      <= 8'h00;
`endif
        end else begin
            if (w_load) begin
                r_frame <= w_src;
                r_csum  <= f_csum(w_src);
                r_idx   <= '0;
                r_busy  <= 1'b1;
`ifdef PKT_SEQ_EN
                r_seq     <= r_seq_cnt;
                r_seq_cnt <= r_seq_cnt + 8'd1;
`endif
            end else if (w_idx_inc) begin
                r_idx <= r_idx + IW'(1);
            end else if (w_finish) begin
                r_busy <= 1'b0;
                r_idx  <= '0;
            end

            if (r_state == ST_SEND) begin
                r_tx_data <= w_byte;
            end

            // When the pending slot drains into the frame register, a report
            // arriving in the same cycle refills it without counting a drop.
            if (w_load_pend) begin
                r_pend_vld <= bus.rpt_vld;
                if (bus.rpt_vld) begin
                    r_pend <= bus.rpt_data;
                end
            end else if (bus.rpt_vld && !w_load_in) begin
                if (r_pend_vld && (r_drop != 8'hFF)) begin
                    r_drop <= r_drop + 8'd1;
                end
                r_pend     <= bus.rpt_data;
                r_pend_vld <= 1'b1;
            end
        end
    end

    assign bus.trmt     = (r_state == ST_SEND);
    assign bus.tx_data  = (r_state == ST_SEND) ? w_byte : r_tx_data;
    assign bus.busy     = r_busy;
    assign bus.drop_cnt = r_drop;

endmodule

// File: tb/tb_ctrl_report_packetizer.sv
// Purpose : self-checking bench for ctrl_report_packetizer against a frame-level reference model.
// Latency : n/a.
// Backpressure: the bench models the UART transmitter's tx_done level with random or fixed delays.
`timescale 1ns/1ps
module tb_ctrl_report_packetizer;
    localparam int NB = 4;
    localparam int DW = 8 * NB;
`ifdef PKT_SEQ_EN
    localparam int FLEN = NB + 3;
`else
    localparam int FLEN = NB + 2;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ctrl_report_packetizer_if #(.NUM_BYTES(NB)) bus();

    ctrl_report_packetizer #(
        .NUM_BYTES (NB),
        .HDR_BYTE  (8'hA5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: frames as byte lists, one pending report slot.
    logic [7:0]    exp_q[$];
    logic [7:0]    log_q[$];
    int            trmt_cyc_q[$];
    bit            m_active;
    bit            m_pend_v;
    logic [DW-1:0] m_pend;
    int            m_sent;
    int            m_last_trmt;
    logic [7:0]    m_drop;
    logic [7:0]    m_seq;
    int            cyc;

    // Transmitter model
    bit stale;
    int dly_min;
    int dly_max;
    int cnt;

    task automatic model_start(input logic [DW-1:0] d);
        int sum;
        sum = 0;
        exp_q.push_back(8'hA5);
`ifdef PKT_SEQ_EN
        exp_q.push_back(m_seq);
        m_seq = m_seq + 8'd1;
`endif
        for (int i = NB - 1; i >= 0; i--) begin
            exp_q.push_back(d[8*i +: 8]);
            sum = sum + int'(d[8*i +: 8]);
        end
        exp_q.push_back(8'((256 - (sum % 256)) % 256));
        m_active = 1'b1;
        m_sent   = 0;
    endtask

    task automatic cycle(input logic vld, input logic [DW-1:0] data);
        logic       t;
        logic [7:0] b;
        logic       nd;
        bit         complete;
        @(negedge clk);
        cyc++;
        chk("busy", 32'(bus.busy), 32'(m_active));
        chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
        t = bus.trmt;
        b = bus.tx_data;
        if (t) begin
            log_q.push_back(b);
            trmt_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) chk("unexpected_trmt", 32'(b), 32'hFFFF_FFFF);
            else chk("tx_data", 32'(b), 32'(exp_q.pop_front()));
            m_sent++;
            m_last_trmt = cyc;
        end

        nd = bus.tx_done;
        if (stale) begin
            nd = 1'b1;
        end else if (t) begin
            nd  = 1'b0;
            cnt = int'($urandom_range(dly_max, dly_min));
        end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) nd = 1'b1;
        end
        bus.tx_done  = nd;
        bus.rpt_vld  = vld;
        bus.rpt_data = data;

        // Frame ends on the first tx_done seen at least two cycles after its last byte.
        complete = m_active && (m_sent == FLEN) && (cyc >= m_last_trmt + 2) && (nd == 1'b1);
        if (!m_active) begin
            if (m_pend_v) begin
                model_start(m_pend);
                m_pend_v = vld;
                if (vld) m_pend = data;
            end else if (vld) begin
                model_start(data);
            end
        end else if (complete) begin
            if (m_pend_v) begin
                model_start(m_pend);
                m_pend_v = vld;
                if (vld) m_pend = data;
            end else begin
                m_active = 1'b0;
                if (vld) begin
                    m_pend_v = 1'b1;
                    m_pend   = data;
                end
            end
        end else if (vld) begin
            if (m_pend_v && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
            m_pend   = data;
            m_pend_v = 1'b1;
        end
    endtask

    task automatic do_reset();
        bus.rpt_vld = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_trmt", 32'(bus.trmt), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_drop", 32'(bus.drop_cnt), 32'h0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_active    = 1'b0;
        m_pend_v    = 1'b0;
        m_drop      = 8'h00;
        m_seq       = 8'h00;
        m_sent      = 0;
        m_last_trmt = 0;
        cnt         = 0;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((m_active || m_pend_v || exp_q.size() != 0) && n < limit) begin
            cycle(1'b0, '0);
            n++;
        end
        chk("drain_timeout", 32'(m_active || m_pend_v || exp_q.size() != 0), 32'h0);
        repeat (3) cycle(1'b0, '0);
    endtask

    task automatic clr_log();
        log_q.delete();
        trmt_cyc_q.delete();
    endtask

    // Compare the observed byte log with n bytes packed right-aligned in v.
    task automatic chk_log(input string tag, input logic [127:0] v, input int n);
        chk({tag, "_len"}, 32'(log_q.size()), 32'(n));
        for (int i = 0; i < n && i < log_q.size(); i++) begin
            chk(tag, 32'(log_q[i]), 32'(v[8*(n-1-i) +: 8]));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tx_done  = 1'b0;
        bus.rpt_vld  = 1'b0;
        bus.rpt_data = '0;
        stale   = 1'b0;
        dly_min = 20;
        dly_max = 20;
        cnt     = 0;
        cyc     = 0;
        do_reset();

        // Single report, transmitter answers 20 cycles after each trmt.
        clr_log();
        cycle(1'b1, 32'h1234_5678);
        drain(2000);
`ifndef PKT_SEQ_EN
        chk_log("t1_bytes", 128'hA5_12_34_56_78_EC, 6);
`endif
        chk("t1_trmt_cnt", 32'(trmt_cyc_q.size()), 32'(FLEN));

        // Second report arrives mid-frame and follows back-to-back.
        clr_log();
        cycle(1'b1, 32'h0000_0001);
        repeat (30) cycle(1'b0, '0);
        cycle(1'b1, 32'hFFFF_FFFF);
        drain(4000);
`ifndef PKT_SEQ_EN
        chk_log("t2_bytes", 128'hA5_00_00_00_01_FF_A5_FF_FF_FF_FF_04, 12);
`endif
        chk("t2_drop", 32'(bus.drop_cnt), 32'h0);

        // Three reports during one frame: the middle one is overwritten.
        clr_log();
        cycle(1'b1, 32'h1111_1111);
        repeat (10) cycle(1'b0, '0);
        cycle(1'b1, 32'h2222_2222);
        repeat (10) cycle(1'b0, '0);
        cycle(1'b1, 32'h3333_3333);
        drain(4000);
`ifndef PKT_SEQ_EN
        chk_log("t3_bytes", 128'hA5_11_11_11_11_BC_A5_33_33_33_33_34, 12);
`endif
        chk("t3_drop", 32'(bus.drop_cnt), 32'h1);

        // Flood of reports: drop counter saturates.
        for (int i = 0; i < 301; i++) cycle(1'b1, $urandom);
        drain(6000);
        chk("t3_drop_sat", 32'(bus.drop_cnt), 32'hFF);

        // Reset while the third byte is awaiting tx_done.
        clr_log();
        cycle(1'b1, 32'hDEAD_BEEF);
        for (int i = 0; i < 500 && trmt_cyc_q.size() < 3; i++) cycle(1'b0, '0);
        chk("t4_third_byte", 32'(trmt_cyc_q.size()), 32'h3);
        repeat (5) cycle(1'b0, '0);
        do_reset();
        clr_log();
        cycle(1'b1, 32'hCAFE_BABE);
        drain(2000);
`ifndef PKT_SEQ_EN
        chk_log("t4_bytes", 128'hA5_CA_FE_BA_BE_C0, 6);
`endif

        // tx_done stuck high: each byte still costs SEND + guard + wait.
        stale = 1'b1;
        clr_log();
        cycle(1'b1, 32'h1234_5678);
        drain(500);
`ifndef PKT_SEQ_EN
        chk_log("t5_bytes", 128'hA5_12_34_56_78_EC, 6);
`endif
        chk("t5_trmt_cnt", 32'(trmt_cyc_q.size()), 32'(FLEN));
        for (int i = 1; i < trmt_cyc_q.size(); i++) begin
            chk("t5_gap", 32'(trmt_cyc_q[i] - trmt_cyc_q[i-1]), 32'h3);
        end
        stale = 1'b0;

        // Random traffic with random transmitter delays.
        dly_min = 1;
        dly_max = 25;
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(29, 0) == 0, $urandom);
        end
        drain(8000);

`ifdef PKT_SEQ_EN
        // Sequence byte counts frames from reset and wraps.
        do_reset();
        stale = 1'b1;
        for (int f = 0; f < 257; f++) begin
            clr_log();
            cycle(1'b1, '0);
            drain(200);
            chk("seq_len", 32'(log_q.size()), 32'h7);
            if (log_q.size() == 7) begin
                chk("seq_byte", 32'(log_q[1]), 32'(f % 256));
                chk("seq_csum", 32'(log_q[6]), 32'h0);
            end
        end
        stale = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
